// File: rtl/pid_incr_seq.sv
// Incremental PID step u(k) = u(k-1) + Kp*de1 + Ki*e0 + Kd*de2 on one shared multiplier, clamped output.
// Optional build macro PID_DEADBAND_EN: zero small errors (|e0| <= DEADBAND) before they enter the step.
module pid_incr_seq #(
    parameter int DW       = 10,
    parameter int KW       = 4,
    parameter int FRAC     = 0,
    parameter int OW       = 15,
    parameter int OUT_MAX  = 16383,
    parameter int OUT_MIN  = -16384,
    parameter int DEADBAND = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic [DW-1:0]        target,
    input  logic [DW-1:0]        y,
    input  logic [KW-1:0]        kp,
    input  logic [KW-1:0]        ki,
    input  logic [KW-1:0]        kd,
    output logic signed [OW-1:0] uk,
    output logic                 uk_valid,
    output logic                 sat_hi,
    output logic                 sat_lo
);
    localparam int EW  = DW + 1;
    localparam int DEW = DW + 3;
    localparam int AW  = DW + KW + 5;
    localparam int SW  = ((OW > AW) ? OW : AW) + 1;
    localparam logic signed [SW-1:0] MAX_S = SW'(OUT_MAX);
    localparam logic signed [SW-1:0] MIN_S = SW'(OUT_MIN);
    localparam logic signed [OW-1:0] MAX_O = OW'(OUT_MAX);
    localparam logic signed [OW-1:0] MIN_O = OW'(OUT_MIN);

    generate
        if (OUT_MIN >= OUT_MAX || DEADBAND < 0) begin : g_bad_cfg
            $error("pid_incr_seq: invalid clamp limits or deadband");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MP, S_MI, S_MD, S_ACC} state_t;

    state_t                 state_q;
    logic [DW-1:0]          target_q, y_q;
    logic [KW-1:0]          kp_q, ki_q, kd_q;
    logic signed [EW-1:0]   e0_q, e1_q, e2_q;
    logic signed [DEW-1:0]  de1_q, de2_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [OW-1:0]   uk_q;
    logic                   uk_valid_q, sat_hi_q, sat_lo_q;

    logic signed [EW-1:0]   e0_raw, e0_d;
    logic signed [DEW-1:0]  e0_x, e1_x, e2_x, de1_d, de2_d, opnd;
    logic [KW-1:0]          gain_mux;
    logic signed [AW-1:0]   mul_a, mul_b, prod_d, d_d;
    logic signed [SW-1:0]   s_d;
    logic signed [OW-1:0]   uk_sat_d;

    assign e0_raw = $signed({1'b0, target_q}) - $signed({1'b0, y_q});

`ifdef PID_DEADBAND_EN
    localparam logic [EW-1:0] DB_U = EW'(DEADBAND);
    logic [EW-1:0] e0_abs;
    assign e0_abs = e0_raw[EW-1] ? EW'(-e0_raw) : EW'(e0_raw);
    assign e0_d   = (e0_abs <= DB_U) ? '0 : e0_raw;
`else
    assign e0_d = e0_raw;
`endif

    // History is kept in the unclamped error domain; de2 = e0 - 2*e1 + e2.
    assign e0_x  = {{(DEW-EW){e0_d[EW-1]}}, e0_d};
    assign e1_x  = {{(DEW-EW){e1_q[EW-1]}}, e1_q};
    assign e2_x  = {{(DEW-EW){e2_q[EW-1]}}, e2_q};
    assign de1_d = e0_x - e1_x;
    assign de2_d = e0_x - (e1_x <<< 1) + e2_x;

    always_comb begin
        gain_mux = kp_q;
        opnd     = de1_q;
        case (state_q)
            S_MI: begin
                gain_mux = ki_q;
                opnd     = {{(DEW-EW){e0_q[EW-1]}}, e0_q};
            end
            S_MD: begin
                gain_mux = kd_q;
                opnd     = de2_q;
            end
            default: ;
        endcase
    end

    assign mul_a  = {{(AW-KW){1'b0}}, gain_mux};
    assign mul_b  = {{(AW-DEW){opnd[DEW-1]}}, opnd};
    assign prod_d = mul_a * mul_b;

    assign d_d      = acc_q >>> FRAC;
    assign s_d      = {{(SW-OW){uk_q[OW-1]}}, uk_q} + {{(SW-AW){d_d[AW-1]}}, d_d};
    assign uk_sat_d = (s_d > MAX_S) ? MAX_O : ((s_d < MIN_S) ? MIN_O : s_d[OW-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            y_q        <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            e0_q       <= '0;
            e1_q       <= '0;
            e2_q       <= '0;
            de1_q      <= '0;
            de2_q      <= '0;
            acc_q      <= '0;
            uk_q       <= '0;
            uk_valid_q <= 1'b0;
            sat_hi_q   <= 1'b0;
            sat_lo_q   <= 1'b0;
        end else if (clr) begin
            state_q    <= S_IDLE;
            e1_q       <= '0;
            e2_q       <= '0;
            acc_q      <= '0;
            uk_q       <= '0;
            uk_valid_q <= 1'b0;
            sat_hi_q   <= 1'b0;
            sat_lo_q   <= 1'b0;
        end else begin
            uk_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sample_valid) begin
                        target_q <= target;
                        y_q      <= y;
                        kp_q     <= kp;
                        ki_q     <= ki;
                        kd_q     <= kd;
                        state_q  <= S_ERR;
                    end
                end
                S_ERR: begin
                    e0_q    <= e0_d;
                    de1_q   <= de1_d;
                    de2_q   <= de2_d;
                    state_q <= S_MP;
                end
                S_MP: begin
                    acc_q   <= prod_d;
                    state_q <= S_MI;
                end
                S_MI: begin
                    acc_q   <= acc_q + prod_d;
                    state_q <= S_MD;
                end
                S_MD: begin
                    acc_q   <= acc_q + prod_d;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    uk_q       <= uk_sat_d;
                    sat_hi_q   <= (s_d > MAX_S);
                    sat_lo_q   <= (s_d < MIN_S);
                    e2_q       <= e1_q;
                    e1_q       <= e0_q;
                    uk_valid_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sample_ready = (state_q == S_IDLE);
    assign uk           = uk_q;
    assign uk_valid     = uk_valid_q;
    assign sat_hi       = sat_hi_q;
    assign sat_lo       = sat_lo_q;
endmodule
